arbiter_burst_rr: RTL and testbench

- Parametrised N-client arbiter in front of the SDRAM controller on the clkSYS domain. Successor to the fixed 4-client priority arbiter.
- Client count, address width and data width are generic. Fixed-priority and round-robin modes are runtime-selectable.
- The grant is held for a full burst, so TFT, ADC and test traffic are never interleaved mid-burst.
- Read data from the controller is routed back to the requesting client by id.

---
 rtl/arbiter_pkg.sv | 37 +++
 rtl/arbiter_pick.sv | 25 ++
 rtl/arbiter_burst_rr.sv | 120 ++++++++++++
 tb/tb_arbiter_burst_rr.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and winner-selection helper for the SDRAM-side client arbiters.
package arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_CLIENTS = 16;

    // Fixed mode: lowest requesting index. Round-robin: first requester at or after
    // ptr+1, wrapping at n. Returns 0 when nobody requests.
    function automatic int pick_next(input logic [MAX_CLIENTS-1:0] req, input int ptr,
                                     input logic mode, input int n);
        int win;
        int idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int k = 1; k <= MAX_CLIENTS; k++) begin
            if (k <= n) begin
                if (mode) begin
                    idx = ptr + k;
                    if (idx >= n) idx = idx - n;
                end else begin
                    idx = k - 1;
                end
                if (!found && req[idx[3:0]]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/arbiter_pick.sv
// Combinational winner selection for an N-client arbiter (fixed or round-robin).
module arbiter_pick
    import arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          mode,
    output logic [CW-1:0] winner,
    output logic          any
);

    logic [MAX_CLIENTS-1:0] req_ext;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
    end

    assign winner = CW'(pick_next(req_ext, int'(ptr), mode, N));
    assign any    = |req;

endmodule

// File: rtl/arbiter_burst_rr.sv
// Burst-holding N-client arbiter in front of the SDRAM controller (clkSYS domain),
// with id-routed read return.
module arbiter_burst_rr
    import arbiter_pkg::*;
#(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int N     = 4,
    parameter int BURST = 8,
    localparam int CW   = $clog2(N)
) (
    input  logic          clkSYS,
    input  logic          n_reset,
    input  logic          rr_mode,
    input  logic [N-1:0]  c_req,
    input  logic [N-1:0]  c_wr,
    input  logic [N*AN-1:0] c_addr,
    input  logic [N*DN-1:0] c_data,
    output logic [N-1:0]  c_ack,
    output logic [N-1:0]  c_valid,
    output logic [DN-1:0] c_mem,
    output logic          m_req,
    output logic          m_wr,
    output logic [AN-1:0] m_addr,
    output logic [DN-1:0] m_data,
    output logic [CW-1:0] m_id,
    input  logic          m_ack,
    input  logic          m_valid,
    input  logic [CW-1:0] m_rid,
    input  logic [DN-1:0] m_mem,
    output logic [CW-1:0] grant_idx,
    output logic          busy
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST = BW'(BURST - 1);

    state_t        state, state_next;
    logic [CW-1:0] grant_idx_next, ptr, ptr_next, winner;
    logic [BW-1:0] count, count_next;
    logic          any_req, accept, release_grant;

    arbiter_pick #(.N(N)) u_pick (
        .req    (c_req),
        .ptr    (ptr),
        .mode   (rr_mode),
        .winner (winner),
        .any    (any_req)
    );

    // Only the owner reaches the controller, and only while the grant is live.
    always_comb begin
        m_req            = (state == GRANT) & c_req[grant_idx];
        m_wr             = (state == GRANT) & c_wr[grant_idx];
        m_addr           = c_addr[grant_idx*AN +: AN];
        m_data           = c_data[grant_idx*DN +: DN];
        m_id             = grant_idx;
        c_ack            = '0;
        c_ack[grant_idx] = m_ack & m_req;
    end

    assign accept = m_req & m_ack;
    assign busy   = (state == GRANT);

    always_comb begin
        state_next     = state;
        grant_idx_next = grant_idx;
        ptr_next       = ptr;
        count_next     = count;
        release_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next     = GRANT;
                    grant_idx_next = winner;
                    count_next     = '0;
                end
            end
            GRANT: begin
                // Full burst done, or the owner gave up without a word in flight.
                release_grant = (accept && count == LAST) || (!c_req[grant_idx] && !accept);
                if (accept) count_next = count + 1'b1;
                if (release_grant) begin
                    state_next = IDLE;
                    ptr_next   = grant_idx;
                    count_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            ptr       <= CW'(N - 1);
            count     <= '0;
        end else begin
            state     <= state_next;
            grant_idx <= grant_idx_next;
            ptr       <= ptr_next;
            count     <= count_next;
        end
    end

    // Read return is independent of the grant; ids outside 0..N-1 match nobody.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            c_valid <= '0;
            c_mem   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                c_valid[i] <= m_valid && (m_rid == CW'(i));
            end
            c_mem <= m_mem;
        end
    end

endmodule

// File: tb/tb_arbiter_burst_rr.sv
// Randomised bench for arbiter_burst_rr: transaction-level grant model feeding an
// expected-word queue, plus a read-return scoreboard.
module tb_arbiter_burst_rr;

    localparam int AN = 24;
    localparam int DN = 16;
    localparam int N = 4;
    localparam int BURST = 8;
    localparam int CW = 2;
    localparam int WW = CW + 1 + AN + DN + 1;

    logic clkSYS = 1'b0;
    logic n_reset = 1'b1;
    logic rr_mode = 1'b0;
    logic [N-1:0] c_req = '0, c_wr = '0;
    logic [N*AN-1:0] c_addr = '0;
    logic [N*DN-1:0] c_data = '0;
    logic [N-1:0] c_ack, c_valid;
    logic [DN-1:0] c_mem;
    logic m_req, m_wr;
    logic [AN-1:0] m_addr;
    logic [DN-1:0] m_data;
    logic [CW-1:0] m_id, grant_idx;
    logic m_ack = 1'b0, m_valid = 1'b0;
    logic [CW-1:0] m_rid = '0;
    logic [DN-1:0] m_mem = '0;
    logic busy;

    arbiter_burst_rr #(.AN(AN), .DN(DN), .N(N), .BURST(BURST)) dut (
        .clkSYS(clkSYS), .n_reset(n_reset), .rr_mode(rr_mode),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_data(c_data),
        .c_ack(c_ack), .c_valid(c_valid), .c_mem(c_mem),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_data(m_data), .m_id(m_id),
        .m_ack(m_ack), .m_valid(m_valid), .m_rid(m_rid), .m_mem(m_mem),
        .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clkSYS = ~clkSYS;

    int n_tests = 0;
    int n_fail = 0;
    logic [WW-1:0] exp_q[$];
    logic [N+DN-1:0] ret_q[$];
    logic sb_en = 1'b0;
    logic ret_en = 1'b0;
    int idle_chk = 0;
    int model_ptr = N - 1;

    int job_len[N];
    int done_w[N];
    logic job_wr[N];
    logic [AN-1:0] job_base[N];
    logic [DN-1:0] job_data[N][64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: whole-phase grant sequence ----------------
    task automatic build_expect(input logic mode_a, input logic mode_b);
        int rem[N];
        int win, chunk, k, total;
        logic mode, first;
        first = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = job_len[i];
        forever begin
            total = 0;
            for (int i = 0; i < N; i++) total += rem[i];
            if (total == 0) break;
            mode = first ? mode_a : mode_b;
            first = 1'b0;
            win = -1;
            if (!mode) begin
                for (int i = N - 1; i >= 0; i--) if (rem[i] > 0) win = i;
            end else begin
                for (int s = N; s >= 1; s--) if (rem[(model_ptr + s) % N] > 0) win = (model_ptr + s) % N;
            end
            chunk = (rem[win] < BURST) ? rem[win] : BURST;
            for (int w = 0; w < chunk; w++) begin
                k = job_len[win] - rem[win] + w;
                exp_q.push_back({CW'(win), job_wr[win], job_base[win] + AN'(k), job_data[win][k],
                                 (w == chunk - 1) && (chunk == BURST)});
            end
            rem[win] -= chunk;
            model_ptr = win;
        end
    endtask

    // ---------------- client / controller driver tasks ----------------
    task automatic set_jobs(input int l0, input int l1, input int l2, input int l3);
        job_len[0] = l0; job_len[1] = l1; job_len[2] = l2; job_len[3] = l3;
        for (int i = 0; i < N; i++) begin
            done_w[i] = 0;
            job_wr[i] = 1'($urandom_range(0, 1));
            job_base[i] = AN'($urandom);
            for (int k = 0; k < 64; k++) job_data[i][k] = DN'($urandom);
        end
    endtask

    task automatic drive_clients();
        int k;
        for (int i = 0; i < N; i++) begin
            k = (done_w[i] < job_len[i]) ? done_w[i] : 0;
            c_req[i] = (done_w[i] < job_len[i]);
            c_wr[i] = job_wr[i];
            c_addr[i*AN +: AN] = job_base[i] + AN'(k);
            c_data[i*DN +: DN] = job_data[i][k];
        end
    endtask

    function automatic logic all_done();
        logic d;
        d = 1'b1;
        for (int i = 0; i < N; i++) if (done_w[i] < job_len[i]) d = 1'b0;
        return d;
    endfunction

    task automatic run_phase(input logic mode_a, input logic mode_b, input int abort_at);
        logic [N-1:0] ackd;
        int acks, budget;
        logic aborted;
        build_expect(mode_a, mode_b);
        rr_mode = mode_a;
        drive_clients();
        acks = 0;
        budget = 0;
        aborted = 1'b0;
        while (budget < 4000 && !aborted) begin
            @(negedge clkSYS);
            ackd = c_ack;
            if (all_done() && !busy) break;
            @(posedge clkSYS);
            #1;
            for (int i = 0; i < N; i++) if (ackd[i]) begin done_w[i]++; acks++; end
            if (acks > 0) rr_mode = mode_b;
            drive_clients();
            m_ack = ($urandom_range(0, 3) != 0);
            if (abort_at > 0 && acks == abort_at) begin
                m_ack = 1'b1;
                #1;
                chk("pre_reset_m_req", m_req, 1);
                chk("pre_reset_busy", busy, 1);
                sb_en = 1'b0;
                ret_en = 1'b0;
                n_reset = 1'b0;
                #1;
                chk("reset_m_req", m_req, 0);
                chk("reset_busy", busy, 0);
                chk("reset_c_ack", c_ack, 0);
                chk("reset_grant_idx", grant_idx, 0);
                chk("reset_m_id", m_id, 0);
                c_req = '0;
                for (int i = 0; i < N; i++) job_len[i] = 0;
                repeat (2) @(posedge clkSYS);
                exp_q.delete();
                ret_q.delete();
                idle_chk = 0;
                model_ptr = N - 1;
                @(negedge clkSYS);
                n_reset = 1'b1;
                sb_en = 1'b1;
                ret_en = 1'b1;
                aborted = 1'b1;
            end
            budget++;
        end
        if (!aborted) begin
            if (budget >= 4000) chk("phase_timeout", 1, 0);
            chk("phase_drain", 64'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    // ---------------- read-return stimulus ----------------
    initial begin
        logic [N-1:0] oh;
        forever begin
            @(posedge clkSYS);
            #1;
            if (ret_en) begin
                m_valid = 1'($urandom_range(0, 1));
                m_rid = CW'($urandom_range(0, N - 1));
                m_mem = DN'($urandom);
                oh = '0;
                if (m_valid) oh[m_rid] = 1'b1;
                ret_q.push_back({oh, m_mem});
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [WW-1:0] e;
    logic [N+DN-1:0] r;
    logic [N-1:0] exp_ack;
    always @(negedge clkSYS) begin
        if (sb_en && n_reset) begin
            if (idle_chk != 0) begin
                chk("idle_gap_busy", busy, 0);
                idle_chk = 0;
            end
            if (m_req && m_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_id_wr_addr_data", {m_id, m_wr, m_addr, m_data}, e[WW-1:1]);
                    exp_ack = '0;
                    exp_ack[e[WW-1 -: CW]] = 1'b1;
                    chk("c_ack_onehot", c_ack, exp_ack);
                    if (e[0]) idle_chk = 1;
                end
            end else begin
                chk("c_ack_idle", c_ack, 0);
            end
            if (ret_q.size() >= 2) begin
                r = ret_q.pop_front();
                chk("c_valid", c_valid, r[N+DN-1:DN]);
                if (|r[N+DN-1:DN]) chk("c_mem", c_mem, r[DN-1:0]);
            end
        end
    end

    // ---------------- clock/reset and phase sequence ----------------
    initial begin
        #2 n_reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_m_id", m_id, 0);
        chk("rst_c_ack", c_ack, 0);
        chk("rst_c_valid", c_valid, 0);
        repeat (3) @(posedge clkSYS);
        @(negedge clkSYS);
        n_reset = 1'b1;
        sb_en = 1'b1;
        ret_en = 1'b1;

        set_jobs(0, 12, 0, 5);    run_phase(1'b0, 1'b0, 0);
        set_jobs(16, 16, 16, 16); run_phase(1'b1, 1'b1, 0);
        set_jobs(0, 0, 3, 0);     run_phase(1'b1, 1'b1, 0);
        set_jobs(5, 9, 0, 4);     run_phase(1'b1, 1'b1, 0);
        set_jobs(10, 10, 10, 10); run_phase(1'b1, 1'b0, 0);
        set_jobs(10, 3, 12, 7);   run_phase(1'b0, 1'b1, 0);
        for (int p = 0; p < 5; p++) begin
            set_jobs($urandom_range(0, 20), $urandom_range(0, 20),
                     $urandom_range(0, 20), $urandom_range(0, 20));
            run_phase(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        set_jobs(0, 0, 8, 0);     run_phase(1'b1, 1'b1, 5);
        set_jobs(6, 6, 6, 6);     run_phase(1'b1, 1'b1, 0);

        repeat (3) @(negedge clkSYS);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
